// File: rtl/product_bcd_display_pkg.sv
// rtl/product_bcd_display_pkg.sv - shared types, sizes and segment patterns for the product BCD display
//
// Contents:
//   state_e   converter FSM encoding (IDLE, SHIFT, DONE)
//   DIGITS    number of displayed decimal digits
//   BCD_W     width of the packed BCD result
//   ITER      number of shift iterations for an 8-bit binary input
//   SEG_*     active-low {g,f,e,d,c,b,a} patterns for 0-9 and blank
//   dd_step   one double-dabble iteration (add-3 correction, then shift left)
package product_bcd_display_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam int DIGITS  = 3;
   localparam int BCD_W   = 12;
   localparam int BIN_W   = 8;
   localparam int SHIFT_W = BCD_W + BIN_W;
   localparam int ITER    = 8;
   localparam int ITER_W  = 4;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // BCD nibbles sit above the binary byte: [19:16] hundreds, [15:12] tens, [11:8] units.
   function automatic logic [SHIFT_W-1:0] dd_step(input logic [SHIFT_W-1:0] v);
      logic [SHIFT_W-1:0] r;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         if (r[BIN_W + 4*i +: 4] >= 4'd5) begin
            r[BIN_W + 4*i +: 4] = r[BIN_W + 4*i +: 4] + 4'd3;
         end
      end
      return {r[SHIFT_W-2:0], 1'b0};
   endfunction

endpackage

// File: rtl/product_bcd_display_seg7_decoder.sv
// rtl/product_bcd_display_seg7_decoder.sv - 4-bit nibble to active-low 7-segment pattern
//
// Ports:
//   nibble_i  4-bit value to display
//   seg_o     {g,f,e,d,c,b,a}, active-low; values 10-15 give all segments off
module seg7_decoder
   import product_bcd_display_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (nibble_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/product_bcd_display.sv
// rtl/product_bcd_display.sv - 8-bit binary to BCD converter with multiplexed 7-segment display
//
// Parameters:
//   REFRESH_DIV  clock cycles each digit is held active while scanning
// Ports:
//   clk      system clock, rising edge
//   reset_n  synchronous active-low reset
//   start    convert `product`; only looked at while idle
//   product  8-bit unsigned value to convert
//   busy     conversion in progress (SHIFT or DONE)
//   done     one-cycle completion pulse, `bcd` valid in the same cycle
//   bcd      registered result {hundreds, tens, units}
//   seg      active-low segments {g,f,e,d,c,b,a} for the scanned digit
//   an       active-low digit anodes; an[0] units .. an[2] hundreds, an[3] unused
//   dp       decimal point, always off
// Build option:
//   LEADING_ZERO_BLANK_EN  blank leading zero hundreds/tens digits
module product_bcd_display
   import product_bcd_display_pkg::*;
#(
   parameter int REFRESH_DIV = 50000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [BIN_W-1:0] product,
   output logic             busy,
   output logic             done,
   output logic [BCD_W-1:0] bcd,
   output logic [6:0]       seg,
   output logic [3:0]       an,
   output logic             dp
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   state_e               state_q, state_d;
   logic [SHIFT_W-1:0]   sr_q, sr_d;
   logic [ITER_W-1:0]    iter_q, iter_d;
   logic [BCD_W-1:0]     bcd_q, bcd_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [1:0]           dig_q, dig_d;
   logic [3:0]           nibble;
   logic [6:0]           seg_dec;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         iter_q  <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         dig_q   <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         iter_q  <= iter_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         dig_q   <= dig_d;
      end
   end

   // The SHIFT state spends one extra cycle after the last shift recognising
   // that all iterations are complete, which places done nine edges after start.
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      iter_d  = iter_q;
      bcd_d   = bcd_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               sr_d    = {{BCD_W{1'b0}}, product};
               iter_d  = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (iter_q == ITER_W'(ITER)) begin
               bcd_d   = sr_q[SHIFT_W-1:BIN_W];
               state_d = ST_DONE;
            end else begin
               sr_d   = dd_step(sr_q);
               iter_d = iter_q + 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy = (state_q != ST_IDLE);
   assign done = (state_q == ST_DONE);
   assign bcd  = bcd_q;

   // Display scan runs regardless of converter state.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      dig_d = dig_q;
      if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
         cnt_d = '0;
         dig_d = (dig_q == 2'(DIGITS - 1)) ? 2'd0 : dig_q + 2'd1;
      end
   end

   always_comb begin
      nibble = bcd_q[3:0];
      an     = 4'b1110;
      case (dig_q)
         2'd1: begin
            nibble = bcd_q[7:4];
            an     = 4'b1101;
         end
         2'd2: begin
            nibble = bcd_q[11:8];
            an     = 4'b1011;
         end
         default: begin
            nibble = bcd_q[3:0];
            an     = 4'b1110;
         end
      endcase
`ifdef LEADING_ZERO_BLANK_EN
      if (dig_q == 2'd2 && bcd_q[11:8] == 4'd0) begin
         an = 4'b1111;
      end
      if (dig_q == 2'd1 && bcd_q[11:8] == 4'd0 && bcd_q[7:4] == 4'd0) begin
         an = 4'b1111;
      end
`endif
   end

   seg7_decoder u_seg7_decoder (
      .nibble_i (nibble),
      .seg_o    (seg_dec)
   );

   assign seg = seg_dec;
   assign dp  = 1'b1;

endmodule

// File: tb/tb_product_bcd_display.sv
// tb/tb_product_bcd_display.sv - self-checking bench for product_bcd_display
module tb_product_bcd_display;

   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [7:0]  product;
   logic        busy;
   logic        done;
   logic [11:0] bcd;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        dp;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   logic [11:0] model_bcd = 12'h000;
   logic [6:0]  segtab [16];

   typedef struct {
      logic [7:0]  p;
      logic [11:0] exp;
      int          glitch;
   } vec_t;
   vec_t vt [8];

   product_bcd_display #(.REFRESH_DIV(DIV)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .product (product),
      .busy    (busy),
      .done    (done),
      .bcd     (bcd),
      .seg     (seg),
      .an      (an),
      .dp      (dp)
   );

   always #5 clk = ~clk;

   // Cycles since reset release; the scanned digit is (cyc / DIV) % 3.
   always @(posedge clk) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   function automatic logic [11:0] ref_bcd(input int p);
      return {4'(p / 100), 4'((p / 10) % 10), 4'(p % 10)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic start_conv(input logic [7:0] p);
      start   = 1'b1;
      product = p;
      @(posedge clk);
      #1;
      start   = 1'b0;
      product = 8'($urandom);
   endtask

   // Called right after start_conv; n counts negedges after the sampling edge.
   task automatic wait_done(input int glitch, output int lat, output bit busy_ok);
      lat = -1;
      busy_ok = 1'b1;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (done === 1'b1) begin
            lat = n;
            start = 1'b0;
            break;
         end
         product = 8'($urandom);
         start   = (n == glitch);
         if (n == glitch) product = 8'd1;
      end
   endtask

   task automatic conv_and_check(input string tag, input logic [7:0] p, input logic [11:0] exp,
                                 input int glitch);
      int lat;
      bit busy_ok;
      int extra;
      start_conv(p);
      wait_done(glitch, lat, busy_ok);
      check({tag, "_latency"}, lat, 9);
      check({tag, "_busy"}, busy_ok, 1);
      check({tag, "_bcd"}, bcd, exp);
      model_bcd = exp;
      extra = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done === 1'b1) extra++;
         if (i == 0) check({tag, "_idle_after"}, busy, 0);
      end
      check({tag, "_single_done"}, extra, 0);
   endtask

   task automatic disp_check(input string tag, input int ncyc);
      int d;
      logic [3:0] nib;
      logic [3:0] exp_an;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         d   = (cyc / DIV) % 3;
         nib = model_bcd[4*d +: 4];
         exp_an = 4'b1111;
         exp_an[d] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
         if (d == 2 && model_bcd[11:8] == 4'd0) exp_an = 4'b1111;
         if (d == 1 && model_bcd[11:4] == 8'd0) exp_an = 4'b1111;
`endif
         check({tag, "_an"}, an, exp_an);
         check({tag, "_seg"}, seg, segtab[nib]);
         if (i == 0) check({tag, "_dp"}, dp, 1);
      end
   endtask

   initial begin
      int lat;
      bit busy_ok;
      int extra;
      int p;

      segtab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                 7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
      vt[0] = '{8'd225, 12'h225, -1};
      vt[1] = '{8'd0,   12'h000, -1};
      vt[2] = '{8'd255, 12'h255, -1};
      vt[3] = '{8'd9,   12'h009, -1};
      vt[4] = '{8'd100, 12'h100, -1};
      vt[5] = '{8'd99,  12'h099, -1};
      vt[6] = '{8'd225, 12'h225, 4};
      vt[7] = '{8'd123, 12'h123, -1};

      reset_n = 1'b0;
      start   = 1'b0;
      product = 8'd0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_bcd", bcd, 12'h000);
      check("rst_an", an, 4'b1110);
      check("rst_seg", seg, 7'h40);
      check("rst_dp", dp, 1);

      for (int i = 0; i < 8; i++) begin
         conv_and_check($sformatf("vec%0d", i), vt[i].p, vt[i].exp, vt[i].glitch);
         check($sformatf("vec%0d_model", i), bcd, ref_bcd(int'(vt[i].p)));
         disp_check($sformatf("vec%0d_disp", i), 3 * DIV + 2);
      end

      // Start held through DONE into IDLE begins the next conversion.
      start_conv(8'd77);
      wait_done(-1, lat, busy_ok);
      check("hold_first_lat", lat, 9);
      check("hold_first_bcd", bcd, 12'h077);
      start   = 1'b1;
      product = 8'd42;
      @(negedge clk);
      check("hold_idle_busy", busy, 0);
      start_conv(8'd42);
      wait_done(-1, lat, busy_ok);
      check("hold_second_lat", lat, 9);
      check("hold_second_bcd", bcd, 12'h042);
      model_bcd = 12'h042;
      @(negedge clk);

      // Reset in the third SHIFT cycle aborts with no done.
      start_conv(8'd225);
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk);
      #1 reset_n = 1'b1;
      model_bcd = 12'h000;
      extra = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done === 1'b1) extra++;
      end
      check("abort_no_done", extra, 0);
      check("abort_busy", busy, 0);
      check("abort_bcd", bcd, 12'h000);
      disp_check("abort_disp", DIV + 1);
      conv_and_check("after_abort", 8'd42, 12'h042, -1);

      for (int r = 0; r < 20; r++) begin
         p = int'($urandom_range(0, 255));
         conv_and_check($sformatf("rnd%0d", r), 8'(p), ref_bcd(p), -1);
         disp_check($sformatf("rnd%0d_disp", r), DIV + 3);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
